// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game sequencer: mole placement, mole/gap timing, hit/miss decoding, BCD score.
// Optional feature macro WHACK_SPEEDUP_EN: each hit shortens the mole time down to a floor.
module whack_game_ctrl #(
    parameter int unsigned MOLE_TIME_CYC = 100000000,
    parameter int unsigned GAP_CYC       = 50000000,
    parameter int unsigned MAX_MISSES    = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] btn,
    output logic [2:0] mole_position,
    output logic       mole_valid,
    output logic       guess_correct,
    output logic       guess_wrong,
    output logic       game_over,
    output logic [3:0] digit_1,
    output logic [3:0] digit_2,
    output logic [3:0] misses
);

    localparam int unsigned MAX_CYC = (MOLE_TIME_CYC > GAP_CYC) ? MOLE_TIME_CYC : GAP_CYC;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYC - 1);
    localparam logic [3:0] MAX_M = 4'(MAX_MISSES);

    typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, OVER} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         lfsr;
    logic [4:0]         btn_q;
    logic               start_q;

    logic [4:0]         btn_edge;
    logic               start_edge;
    logic               lfsr_fb;
    logic [4:0]         target;
    logic               score_max;
    logic [2:0]         cand_mod;
    logic [2:0]         cand;
    logic [3:0]         next_d1;
    logic [3:0]         next_d2;
    logic [TIMER_W-1:0] mole_load;

    assign btn_edge   = btn & ~btn_q;
    assign start_edge = start & ~start_q;
    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign target     = 5'd1 << mole_position;
    assign score_max  = (digit_1 == 4'd9) && (digit_2 == 4'd9);

    // Fold the 3-bit LFSR value onto 5 slots and never repeat the previous slot.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        cand_mod = (lfsr[2:0] >= 3'd5) ? lfsr[2:0] - 3'd5 : lfsr[2:0];
        cand     = cand_mod;
        if (cand_mod == mole_position) begin
            cand = (cand_mod == 3'd4) ? 3'd0 : cand_mod + 3'd1;
        end
    end

    always_comb begin
        next_d1 = digit_1;
        next_d2 = digit_2;
        if (!score_max) begin
            if (digit_2 == 4'd9) begin
                next_d2 = 4'd0;
                next_d1 = digit_1 + 4'd1;
            end else begin
                next_d2 = digit_2 + 4'd1;
            end
        end
    end

`ifdef WHACK_SPEEDUP_EN
    localparam logic [TIMER_W-1:0] MOLE_FULL  = TIMER_W'(MOLE_TIME_CYC);
    localparam logic [TIMER_W-1:0] MOLE_STEP  = TIMER_W'(MOLE_TIME_CYC / 16);
    localparam logic [TIMER_W-1:0] MOLE_FLOOR = TIMER_W'(MOLE_TIME_CYC / 4);

    logic [TIMER_W-1:0] mole_time;

    assign mole_load = mole_time - TIMER_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mole_time <= MOLE_FULL;
        end else if (start_edge && (state == IDLE || state == OVER)) begin
            mole_time <= MOLE_FULL;
        end else if (state == UP && (|btn_edge) && btn == target) begin
            mole_time <= (mole_time >= MOLE_FLOOR + MOLE_STEP) ? mole_time - MOLE_STEP : MOLE_FLOOR;
        end
    end
`else
    assign mole_load = TIMER_W'(MOLE_TIME_CYC - 1);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            lfsr          <= LFSR_SEED;
            btn_q         <= '0;
            start_q       <= 1'b0;
            mole_position <= 3'd0;
            mole_valid    <= 1'b0;
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
            game_over     <= 1'b0;
            digit_1       <= 4'd0;
            digit_2       <= 4'd0;
            misses        <= 4'd0;
        end else begin
            lfsr          <= {lfsr[6:0], lfsr_fb};
            btn_q         <= btn;
            start_q       <= start;
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;

            case (state)
                IDLE: begin
                    mole_valid <= 1'b0;
                    if (start_edge) state <= SPAWN;
                end
                SPAWN: begin
                    mole_position <= cand;
                    timer         <= mole_load;
                    mole_valid    <= 1'b1;
                    state         <= UP;
                end
                UP: begin
                    // A press outranks a simultaneous timeout: exactly one pulse either way.
                    if ((|btn_edge) || timer == '0) begin
                        if ((|btn_edge) && btn == target) begin
                            guess_correct <= 1'b1;
                            digit_1       <= next_d1;
                            digit_2       <= next_d2;
                        end else begin
                            guess_wrong <= 1'b1;
                            if (misses != 4'd15) misses <= misses + 4'd1;
                        end
                        mole_valid <= 1'b0;
                        timer      <= GAP_LOAD;
                        state      <= GAP;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        if (misses == MAX_M || score_max) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            state <= SPAWN;
                        end
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                OVER: begin
                    mole_valid <= 1'b0;
                    if (start_edge) begin
                        digit_1   <= 4'd0;
                        digit_2   <= 4'd0;
                        misses    <= 4'd0;
                        game_over <= 1'b0;
                        state     <= SPAWN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Self-checking bench for whack_game_ctrl: randomized play against a game-rule reference model.
// Define WHACK_SPEEDUP_EN for both files to exercise the shrinking mole time.
module tb_whack_game_ctrl;

    localparam int MOLE_TIME_CYC = 20;
    localparam int GAP_CYC       = 5;
    localparam int MAX_MISSES    = 3;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] btn = '0;
    logic [2:0] mole_position;
    logic       mole_valid, guess_correct, guess_wrong, game_over;
    logic [3:0] digit_1, digit_2, misses;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model of the game, in plain numbers.
    int exp_score     = 0;
    int exp_misses    = 0;
    int exp_pos       = 0;
    int exp_mole_time = MOLE_TIME_CYC;
    int lfsr_now      = LFSR_SEED;
    int lfsr_used     = LFSR_SEED;

    always #5 clk = ~clk;

    whack_game_ctrl #(
        .MOLE_TIME_CYC(MOLE_TIME_CYC),
        .GAP_CYC      (GAP_CYC),
        .MAX_MISSES   (MAX_MISSES),
        .LFSR_SEED    (LFSR_SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn          (btn),
        .mole_position(mole_position),
        .mole_valid   (mole_valid),
        .guess_correct(guess_correct),
        .guess_wrong  (guess_wrong),
        .game_over    (game_over),
        .digit_1      (digit_1),
        .digit_2      (digit_2),
        .misses       (misses)
    );

    function automatic int lfsr_next(input int v);
        return ((v * 2) % 256) + ($countones(8'(v) & 8'hB8) % 2);
    endfunction

    // lfsr_used is the sequence value the DUT saw just before the most recent clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_now  <= LFSR_SEED;
            lfsr_used <= LFSR_SEED;
        end else begin
            lfsr_used <= lfsr_now;
            lfsr_now  <= lfsr_next(lfsr_now);
        end
    end

    function automatic int slot_from(input int used, input int prev);
        int c;
        c = used % 8;
        if (c >= 5) c = c - 5;
        if (c == prev) c = (c + 1) % 5;
        return c;
    endfunction

    function automatic logic [4:0] onehot(input int p);
        logic [4:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [4:0] wrong_btn(input int p);
        logic [4:0] v;
        v = onehot(p);
        while (v == onehot(p)) v = 5'($urandom_range(1, 31));
        return v;
    endfunction

    task automatic model_restart();
        exp_score     = 0;
        exp_misses    = 0;
        exp_mole_time = MOLE_TIME_CYC;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for mole_valid and checks the slot the model predicts.
    task automatic await_mole(output int waited);
        int exp_slot;
        waited = 0;
        while (mole_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (mole_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL mole_wait: mole_valid=%b after %0d cycles, required 1", mole_valid, waited);
        end
        exp_slot = slot_from(lfsr_used, exp_pos);
        n_checks++;
        if (mole_position !== 3'(exp_slot)) begin
            n_fails++;
            $display("FAIL mole_slot: got %0d required %0d", mole_position, exp_slot);
        end
        n_checks++;
        if (mole_position === 3'(exp_pos)) begin
            n_fails++;
            $display("FAIL mole_repeat: got %0d, required a slot other than %0d", mole_position, exp_pos);
        end
        exp_pos = exp_slot;
    endtask

    // Presses b after delay cycles of UP and checks the resulting event and counters.
    task automatic play_event(input logic [4:0] b, input int delay, input string tag);
        logic hit;
        repeat (delay) @(negedge clk);
        btn = b;
        @(negedge clk);
        btn = '0;
        hit = (b == onehot(exp_pos));
        if (hit) begin
            if (exp_score < 99) exp_score++;
`ifdef WHACK_SPEEDUP_EN
            exp_mole_time = (exp_mole_time - MOLE_TIME_CYC / 16 < MOLE_TIME_CYC / 4)
                          ? MOLE_TIME_CYC / 4 : exp_mole_time - MOLE_TIME_CYC / 16;
`endif
        end else if (exp_misses < 15) begin
            exp_misses++;
        end
        n_checks++;
        if ({guess_correct, guess_wrong} !== (hit ? 2'b10 : 2'b01)) begin
            n_fails++;
            $display("FAIL %s_pulse: got correct/wrong=%b required %b", tag,
                     {guess_correct, guess_wrong}, hit ? 2'b10 : 2'b01);
        end
        n_checks++;
        if ({digit_1, digit_2, misses, mole_valid} !==
            {4'(exp_score / 10), 4'(exp_score % 10), 4'(exp_misses), 1'b0}) begin
            n_fails++;
            $display("FAIL %s_state: got score=%0d%0d misses=%0d valid=%b required %0d misses=%0d valid=0",
                     tag, digit_1, digit_2, misses, mole_valid, exp_score, exp_misses);
        end
        @(negedge clk);
        n_checks++;
        if ({guess_correct, guess_wrong} !== 2'b00) begin
            n_fails++;
            $display("FAIL %s_pulse_len: got correct/wrong=%b one cycle later, required 00", tag,
                     {guess_correct, guess_wrong});
        end
    endtask

    // Lets the mole time run out; measures latency from mole_valid rising to guess_wrong.
    task automatic timeout_event(output int latency);
        latency = 0;
        while (guess_wrong !== 1'b1 && latency < exp_mole_time + 5) begin
            @(negedge clk);
            latency++;
        end
        if (exp_misses < 15) exp_misses++;
        n_checks++;
        if (latency != exp_mole_time || guess_correct !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_latency: got %0d cycles (correct=%b) required %0d",
                     latency, guess_correct, exp_mole_time);
        end
        n_checks++;
        if (misses !== 4'(exp_misses) || mole_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_misses: got %0d valid=%b required %0d valid=0",
                     misses, mole_valid, exp_misses);
        end
        @(negedge clk);
        n_checks++;
        if (guess_wrong !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_pulse_len: got guess_wrong=%b required 0", guess_wrong);
        end
    endtask

    // Runs out the blank interval and checks whether the game ends or a new mole appears.
    task automatic finish_gap(output logic over);
        int waited;
        over = (exp_misses == MAX_MISSES) || (exp_score == 99);
        repeat (3) @(negedge clk);
        n_checks++;
        if (game_over !== 1'b0 || mole_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL gap_early: got game_over=%b valid=%b during blank, required 0/0",
                     game_over, mole_valid);
        end
        @(negedge clk);
        n_checks++;
        if (game_over !== over) begin
            n_fails++;
            $display("FAIL gap_end_over: got game_over=%b required %b", game_over, over);
        end
        if (!over) begin
            await_mole(waited);
            n_checks++;
            if (waited != 1) begin
                n_fails++;
                $display("FAIL gap_length: new mole %0d cycles after blank end, required 1", waited);
            end
        end
    endtask

    task automatic test_reset();
        int   waited;
        logic bad;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mole_position, mole_valid, guess_correct, guess_wrong, game_over, digit_1, digit_2, misses} !== '0) begin
            n_fails++;
            $display("FAIL reset_values: got pos=%0d valid=%b go=%b score=%0d%0d misses=%0d required all 0",
                     mole_position, mole_valid, game_over, digit_1, digit_2, misses);
        end
        rst = 1'b1;
        exp_pos = 0;
        model_restart();
        @(negedge clk);
        start_pulse();
        await_mole(waited);
        repeat (3) @(negedge clk);
        btn = onehot(exp_pos);
        rst = 1'b0;
        #1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ({mole_position, mole_valid, guess_correct, guess_wrong, game_over, digit_1, digit_2, misses} !== '0)
                bad = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_up: got a non-zero output while reset low, required all 0");
        end
        rst = 1'b1;
        exp_pos = 0;
        model_restart();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mole_valid || guess_correct || guess_wrong || game_over) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: got activity without a start edge, required idle");
        end
        btn = '0;
        @(negedge clk);
    endtask

    task automatic test_first_hit();
        int   waited;
        logic over;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (mole_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL start_latency1: got mole_valid=%b one cycle after start, required 0", mole_valid);
        end
        @(negedge clk);
        n_checks++;
        if (mole_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL start_latency2: got mole_valid=%b two cycles after start, required 1", mole_valid);
        end
        await_mole(waited);
        play_event(onehot(exp_pos), $urandom_range(0, 10), "first_hit");
        n_checks++;
        if (digit_2 !== 4'd1 || digit_1 !== 4'd0) begin
            n_fails++;
            $display("FAIL first_hit_score: got %0d%0d required 01", digit_1, digit_2);
        end
        finish_gap(over);
    endtask

    task automatic test_wrong_press();
        logic over;
        play_event(onehot((exp_pos + 1 + $urandom_range(0, 3)) % 5), $urandom_range(0, 10), "wrong_single");
        finish_gap(over);
        play_event(onehot(exp_pos) | onehot((exp_pos + 2) % 5), $urandom_range(0, 10), "wrong_multi");
        n_checks++;
        if (misses !== 4'd2 || digit_2 !== 4'd1) begin
            n_fails++;
            $display("FAIL wrong_totals: got misses=%0d ones=%0d required 2 and 1", misses, digit_2);
        end
        finish_gap(over);
    endtask

    task automatic test_timeout_game_over();
        int   lat;
        int   waited;
        logic over;
        timeout_event(lat);
        finish_gap(over);
        n_checks++;
        if (game_over !== 1'b1 || over !== 1'b1) begin
            n_fails++;
            $display("FAIL third_miss_over: got game_over=%b required 1", game_over);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({game_over, mole_valid, digit_1, digit_2, misses} !== {1'b1, 1'b0, 4'd0, 4'd1, 4'd3}) begin
            n_fails++;
            $display("FAIL over_hold: got go=%b valid=%b score=%0d%0d misses=%0d required 1 0 01 3",
                     game_over, mole_valid, digit_1, digit_2, misses);
        end
        start_pulse();
        model_restart();
        n_checks++;
        if ({game_over, digit_1, digit_2, misses} !== '0) begin
            n_fails++;
            $display("FAIL restart_clear: got go=%b score=%0d%0d misses=%0d required all 0",
                     game_over, digit_1, digit_2, misses);
        end
        await_mole(waited);
    endtask

    task automatic test_hit_at_timeout();
        logic over;
        play_event(onehot(exp_pos), exp_mole_time - 1, "hit_at_timeout");
        n_checks++;
        if (misses !== 4'd0) begin
            n_fails++;
            $display("FAIL hit_at_timeout_miss: got misses=%0d required 0", misses);
        end
        finish_gap(over);
    endtask

    task automatic test_hold_through_gap();
        int         waited;
        logic       bad;
        logic       over;
        logic [4:0] held;
        held = onehot(exp_pos);
        btn  = held;
        @(negedge clk);
        exp_score++;
`ifdef WHACK_SPEEDUP_EN
        exp_mole_time = exp_mole_time - MOLE_TIME_CYC / 16;
`endif
        n_checks++;
        if (guess_correct !== 1'b1 || digit_2 !== 4'(exp_score % 10)) begin
            n_fails++;
            $display("FAIL hold_hit: got correct=%b ones=%0d required 1 and %0d",
                     guess_correct, digit_2, exp_score % 10);
        end
        bad = 1'b0;
        for (int i = 0; i < GAP_CYC; i++) begin
            @(negedge clk);
            if (i == 1) btn = held | onehot((exp_pos + 2) % 5);
            if (i == 2) btn = held;
            if (guess_correct || guess_wrong) bad = 1'b1;
        end
        await_mole(waited);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (guess_correct || guess_wrong) bad = 1'b1;
        end
        btn = '0;
        @(negedge clk);
        if (guess_correct || guess_wrong) bad = 1'b1;
        n_checks++;
        if (bad !== 1'b0 || misses !== 4'(exp_misses)) begin
            n_fails++;
            $display("FAIL hold_no_event: got a pulse or miss change (misses=%0d) required none", misses);
        end
        play_event(onehot(exp_pos), 0, "hold_repress");
        finish_gap(over);
    endtask

    task automatic test_random_play();
        int   k;
        int   lat;
        int   events;
        logic over;
        over   = 1'b0;
        events = 0;
        while (!over && events < 300) begin
            k = $urandom_range(0, 19);
            if (k < 14) play_event(onehot(exp_pos), $urandom_range(0, exp_mole_time - 2), "rand_hit");
            else if (k < 18) play_event(wrong_btn(exp_pos), $urandom_range(0, exp_mole_time - 2), "rand_wrong");
            else timeout_event(lat);
            finish_gap(over);
            events++;
        end
        n_checks++;
        if (game_over !== 1'b1 || misses !== 4'(MAX_MISSES)) begin
            n_fails++;
            $display("FAIL random_end: got game_over=%b misses=%0d after %0d events, required 1 and %0d",
                     game_over, misses, events, MAX_MISSES);
        end
    endtask

    task automatic test_score_99();
        int   waited;
        logic over;
        start_pulse();
        model_restart();
        await_mole(waited);
        over = 1'b0;
        for (int i = 0; i < 99 && !over; i++) begin
            play_event(onehot(exp_pos), $urandom_range(0, 2), "score_hit");
            if (i == 9) begin
                n_checks++;
                if (digit_1 !== 4'd1 || digit_2 !== 4'd0) begin
                    n_fails++;
                    $display("FAIL bcd_carry: got %0d%0d after ten hits, required 10", digit_1, digit_2);
                end
            end
            finish_gap(over);
        end
        n_checks++;
        if ({game_over, digit_1, digit_2} !== {1'b1, 4'd9, 4'd9}) begin
            n_fails++;
            $display("FAIL score_99_over: got go=%b score=%0d%0d required 1 and 99",
                     game_over, digit_1, digit_2);
        end
        start_pulse();
        model_restart();
        n_checks++;
        if ({game_over, digit_1, digit_2, misses} !== '0) begin
            n_fails++;
            $display("FAIL restart_after_99: got go=%b score=%0d%0d misses=%0d required all 0",
                     game_over, digit_1, digit_2, misses);
        end
        await_mole(waited);
    endtask

    task automatic test_mole_time();
        int   lat;
        logic over;
        for (int i = 0; i < 15; i++) begin
            play_event(onehot(exp_pos), $urandom_range(0, 2), "speed_hit");
            finish_gap(over);
        end
        timeout_event(lat);
        n_checks++;
`ifdef WHACK_SPEEDUP_EN
        if (lat != MOLE_TIME_CYC / 4) begin
            n_fails++;
            $display("FAIL mole_time_floor: got %0d cycles required %0d", lat, MOLE_TIME_CYC / 4);
        end
`else
        if (lat != MOLE_TIME_CYC) begin
            n_fails++;
            $display("FAIL mole_time_const: got %0d cycles required %0d", lat, MOLE_TIME_CYC);
        end
`endif
        finish_gap(over);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_hit();
        test_wrong_press();
        test_timeout_game_over();
        test_hit_at_timeout();
        test_hold_through_gap();
        test_random_play();
        test_score_99();
        test_mole_time();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
- Game sequencer for the whack-a-mole display path.
- Picks pseudo-random mole slots, times how long each mole stays up and decodes player button presses into hit/miss events.
- Keeps the BCD score and the miss count, and raises game-over.
- Its outputs drive the VGA display block directly: mole_position, guess_correct, guess_wrong, game_over, digit_1, digit_2.

Parameters:
- MOLE_TIME_CYC, 100000000, clk cycles a mole stays up (1 s at 100 MHz).
- GAP_CYC, 50000000, clk cycles of blank/feedback time between moles.
- MAX_MISSES, 3, misses that end the game (range 1-15).
- LFSR_SEED, 8'hA5, non-zero reset seed of the slot LFSR.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  debounced start button, level; rising edge is the event.
- btn  in  5  debounced slot buttons; bit0 top, bit1 left, bit2 center, bit3 right, bit4 bottom.
- mole_position  out  3  current slot, 0 top, 1 left, 2 center, 3 right, 4 bottom; never 5-7.
- mole_valid  out  1  high while a mole is up.
- guess_correct  out  1  one-cycle pulse on a hit.
- guess_wrong  out  1  one-cycle pulse on a wrong press or timeout.
- game_over  out  1  level, high in OVER.
- digit_1  out  4  score tens, BCD.
- digit_2  out  4  score ones, BCD.
- misses  out  4  miss count.

Behaviour:
- Reset values (async on rst=0): state IDLE, mole_position 0, mole_valid 0, guess_correct 0, guess_wrong 0, game_over 0, digits 0, misses 0, timer 0, LFSR = LFSR_SEED, btn_q/start_q 0.
- All outputs are registered.
- Edge detect: btn_q and start_q are registered copies. edge = in & ~q. A press is seen at the first rising clk edge where the input samples 1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps every cycle in every state.
- IDLE:
  - mole_valid 0.
  - start edge -> SPAWN.
- SPAWN (1 cycle):
  - cand = lfsr[2:0]; if cand >= 5, cand -= 5.
  - If cand == current mole_position, cand = (cand+1) mod 5.
  - Load mole_position = cand and timer = MOLE_TIME_CYC-1 -> UP.
- UP: mole_valid 1; timer decrements each cycle.
  - Any btn edge, btn == one-hot of mole_position: hit. guess_correct=1 on that same clk edge, score += 1, -> GAP.
  - Any btn edge, otherwise (wrong bit, or several bits set): guess_wrong=1, misses += 1, -> GAP.
  - Timer == 0 with no edge: timeout. guess_wrong=1, misses += 1, -> GAP.
  - Press and timeout in the same cycle: the press wins; exactly one pulse.
- GAP:
  - mole_valid 0; timer = GAP_CYC-1 loaded on entry.
  - Button edges are ignored and consumed; a button held across GAP does not fire in the next UP.
  - At timer 0: if misses == MAX_MISSES or score == 99 -> OVER, else -> SPAWN.
- OVER:
  - game_over 1, mole_valid 0; score and misses hold.
  - start edge -> clear score/misses, game_over 0 -> SPAWN.
- start edges in SPAWN/UP/GAP are ignored.
- Score: 2-digit BCD. Ones wrap 9->0 with carry into tens; saturates at 99. misses saturates at 15.
- Pulses last exactly 1 cycle and never assert together.
- Reset mid-game aborts immediately to the reset values; no pulse is emitted.

Optional Feature:
- Macro: WHACK_SPEEDUP_EN.
- Defined: each hit shortens the mole time by MOLE_TIME_CYC/16. The floor is MOLE_TIME_CYC/4. The mole time is restored to MOLE_TIME_CYC on a start edge.
- Undefined: mole time is constantly MOLE_TIME_CYC; no extra registers.

Test Plan (MOLE_TIME_CYC=20, GAP_CYC=5, MAX_MISSES=3):
- rst=0 mid-UP with btn active -> all outputs 0 while low; after release, idle with mole_valid 0 until a start edge.
- start edge -> mole_valid=1 two cycles later. Press the btn bit matching mole_position -> guess_correct high exactly 1 cycle, digit_2=1, mole_valid 0 next cycle, new mole after 5 GAP cycles, new mole_position differs from the previous one.
- Mole at slot 2, press btn=5'b00001 -> guess_wrong 1 cycle, misses=1, score unchanged. Press btn=5'b00110 -> wrong, misses=2.
- No press -> guess_wrong on the 20th cycle after mole_valid rose. Third miss -> game_over=1 after the 5-cycle GAP. start edge -> digits 0, misses 0, game_over 0.
- Ten hits -> digit_1=1, digit_2=0. 99 hits -> game_over=1; further starts restart from 00.
- Hold a correct btn through GAP into the next UP -> no event until release and re-press. Under WHACK_SPEEDUP_EN, 15 hits -> mole time 5 cycles (floor).
